// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: 4-digit multiplexed active-low 7-segment driver with frame-synchronous double buffering (clk, rst async active-low; load/data/dp/blank in; pending, frame, an, seg, dp_n out)
module seven_seg_scanner #(
  parameter int unsigned DIGIT_CYCLES = 262144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  output logic        pending,
  output logic        frame,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n
);
  logic [31:0] cnt;
  logic [1:0]  ptr;
  logic        tc;
  logic [15:0] stg_data, disp_data;
  logic [3:0]  stg_dp, stg_blank, disp_dp, disp_blank;
  logic [3:0]  nib;
  logic [6:0]  hex;
  assign tc = cnt == DIGIT_CYCLES - 1;
  assign frame = tc && ptr == 2'd3;
  assign nib = disp_data[{ptr, 2'b00} +: 4];
  always_comb begin
    hex = 7'h7F;
    case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      4'hF: hex = 7'h0E;
      default: hex = 7'h7F;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt        <= '0;
      ptr        <= '0;
      stg_data   <= '0;
      stg_dp     <= '0;
      stg_blank  <= 4'hF;
      disp_data  <= '0;
      disp_dp    <= '0;
      disp_blank <= 4'hF;
      pending    <= 1'b0;
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp_n       <= 1'b1;
    end else begin
      cnt <= tc ? '0 : cnt + 32'd1;
      if (tc) ptr <= ptr + 2'd1;
      // display takes the old staging even when a load lands on the same boundary
      if (frame && pending) begin
        disp_data  <= stg_data;
        disp_dp    <= stg_dp;
        disp_blank <= stg_blank;
      end
      if (load) begin
        stg_data  <= data;
        stg_dp    <= dp;
        stg_blank <= blank;
      end
      pending <= load | (pending & ~frame);
      an      <= disp_blank[ptr] ? 4'hF : ~(4'b0001 << ptr);
      seg     <= disp_blank[ptr] ? 7'h7F : hex;
      dp_n    <= disp_blank[ptr] | ~disp_dp[ptr];
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: scoreboard bench for seven_seg_scanner with DIGIT_CYCLES=4
module tb_seven_seg_scanner;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic        pending, frame, dp_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  int n_chk = 0;
  int n_err = 0;
  typedef struct {
    logic       pend;
    logic       frm;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dpn;
  } exp_t;
  exp_t q[$];
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int mk;
  logic [15:0] sd, dd;
  logic [3:0]  sp, sb, dpp, db;
  logic        mpend;
  seven_seg_scanner #(.DIGIT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .dp(dp), .blank(blank),
    .pending(pending), .frame(frame), .an(an), .seg(seg), .dp_n(dp_n)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, ".an"}, 32'(an), 32'hF);
    check({tag, ".seg"}, 32'(seg), 32'h7F);
    check({tag, ".dp_n"}, 32'(dp_n), 32'h1);
    check({tag, ".pending"}, 32'(pending), 32'h0);
    check({tag, ".frame"}, 32'(frame), 32'h0);
  endtask
  task automatic model_reset();
    mk = 0;
    sd = '0; sp = '0; sb = 4'hF;
    dd = '0; dpp = '0; db = 4'hF;
    mpend = 1'b0;
    q.delete();
    q.push_back('{1'b0, 1'b0, 4'hF, 7'h7F, 1'b1});
  endtask
  task automatic tick(input logic l, input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    exp_t e, nx;
    int dig;
    logic [15:0] sh;
    if (q.size() == 0) check("queue_empty", 32'h1, 32'h0);
    else begin
      e = q.pop_front();
      check("pending", 32'(pending), 32'(e.pend));
      check("frame", 32'(frame), 32'(e.frm));
      check("an", 32'(an), 32'(e.an));
      check("seg", 32'(seg), 32'(e.seg));
      check("dp_n", 32'(dp_n), 32'(e.dpn));
    end
    load = l; data = d; dp = p; blank = b;
    dig = (mk / 4) % 4;
    sh = dd >> (4 * dig);
    nx.an  = db[dig] ? 4'hF : ~(4'(1) << dig);
    nx.seg = db[dig] ? 7'h7F : hex_tab[sh[3:0]];
    nx.dpn = db[dig] | ~dpp[dig];
    if (mk % 16 == 15 && mpend) begin
      dd = sd; dpp = sp; db = sb; mpend = 1'b0;
    end
    if (l) begin
      sd = d; sp = p; sb = b; mpend = 1'b1;
    end
    mk++;
    nx.pend = mpend;
    nx.frm = (mk % 16 == 15);
    q.push_back(nx);
    @(negedge clk);
  endtask
  task automatic scn(input int n,
                     input int c1, input logic [15:0] d1, input logic [3:0] p1, input logic [3:0] b1,
                     input int c2, input logic [15:0] d2, input logic [3:0] p2, input logic [3:0] b2);
    for (int k = 0; k < n; k++)
      if (k == c1) tick(1'b1, d1, p1, b1);
      else if (k == c2) tick(1'b1, d2, p2, b2);
      else tick(1'b0, 16'h0, 4'h0, 4'h0);
    load = 1'b0;
  endtask
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1 check_reset_outputs(tag);
    repeat (3) @(negedge clk);
    check_reset_outputs({tag, "_held"});
    rst = 1'b1;
    model_reset();
  endtask
  initial begin
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    model_reset();
    scn(40, 2, 16'h12AF, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
    async_reset("async_reset");
    scn(40, 2, 16'h1111, 4'h0, 4'h0, 5, 16'h2222, 4'h0, 4'h0);
    async_reset("rst_overwrite");
    scn(50, 2, 16'h3333, 4'h0, 4'h0, 15, 16'h4444, 4'h0, 4'h0);
    async_reset("rst_coincident");
    scn(40, 2, 16'h8888, 4'b0001, 4'b0100, -1, 16'h0, 4'h0, 4'h0);
    async_reset("rst_blank_dp");
    scn(8, 2, 16'h5A5A, 4'hF, 4'h0, -1, 16'h0, 4'h0, 4'h0);
    async_reset("rst_mid_pending");
    scn(40, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
